// File: rtl/rapid_pkg.sv
// Shared types and constants for the RAPID core front end.
// Holds the prefetch FSM encoding and the fetch defaults.
package rapid_pkg;

   localparam int          WORD_WIDTH   = 4;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      FQ_IDLE,
      FQ_REQ,
      FQ_DISCARD
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instr} pairs feeding decode.
// A flush empties the queue and overrides any same-cycle push or pop.
module fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       push,
   input  logic [XLEN-1:0]            push_pc,
   input  logic [XLEN-1:0]            push_instr,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [XLEN-1:0]            head_pc,
   output logic [XLEN-1:0]            head_instr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic            do_pop;
   logic            do_push;

   // Pops on an empty queue are dropped; a push into a full queue only lands if a pop frees a slot.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign head_pc    = pc_mem[rd_ptr];
   assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: runs sequential reads ahead of decode into a small queue,
// with redirect/flush, stale-read discard and halt.
module prefetch_unit
   import rapid_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              DEPTH        = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rapid_pkg::RESET_VECTOR)
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_halt,
   input  logic                       i_redirect,
   input  logic [XLEN-1:0]            i_redirect_pc,
   output logic                       o_mem_req,
   output logic [XLEN-1:0]            o_mem_addr,
   input  logic                       i_mem_done,
   input  logic [XLEN-1:0]            i_mem_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [XLEN-1:0]            o_pc,
   output logic [XLEN-1:0]            o_instr,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output fetch_state_t               o_state
);

   localparam int CW = $clog2(DEPTH+1);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fetch_pc_next;
   logic [XLEN-1:0] redirect_target;
   logic [CW-1:0]   count_after_pop;
   logic            pop;
   logic            push;
   logic            flush;

   assign pop             = o_valid && i_ready;
   assign count_after_pop = o_count - CW'(pop);
   assign redirect_target = i_redirect_pc & ~XLEN'(3);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= FQ_IDLE;
         fetch_pc <= RESET_VECTOR;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
      end
   end

   // A new request is only started with a free slot, so the single outstanding read can always be pushed.
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      push          = 1'b0;
      flush         = 1'b0;
      if (i_redirect) begin
         flush         = 1'b1;
         fetch_pc_next = redirect_target;
      end
      unique case (state)
         FQ_IDLE: begin
            if (i_redirect) begin
               state_next = i_halt ? FQ_IDLE : FQ_REQ;
            end else if (!i_halt && (count_after_pop < CW'(DEPTH))) begin
               state_next = FQ_REQ;
            end
         end
         FQ_REQ: begin
            if (i_redirect) begin
               if (i_mem_done) begin
                  state_next = i_halt ? FQ_IDLE : FQ_REQ;
               end else begin
                  state_next = FQ_DISCARD;
               end
            end else if (i_mem_done) begin
               push          = 1'b1;
               fetch_pc_next = fetch_pc + XLEN'(WORD_WIDTH);
               if (!i_halt && (count_after_pop < CW'(DEPTH - 1))) begin
                  state_next = FQ_REQ;
               end else begin
                  state_next = FQ_IDLE;
               end
            end
         end
         FQ_DISCARD: begin
            // The returning word belongs to the pre-redirect stream and is dropped.
            if (!i_redirect && i_mem_done) begin
               state_next = i_halt ? FQ_IDLE : FQ_REQ;
            end
         end
         default: begin
            state_next = FQ_IDLE;
         end
      endcase
   end

   fetch_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .push       (push),
      .push_pc    (fetch_pc),
      .push_instr (i_mem_data),
      .pop        (pop),
      .flush      (flush),
      .count      (o_count),
      .head_pc    (o_pc),
      .head_instr (o_instr)
   );

   assign o_mem_req  = (state != FQ_IDLE);
   assign o_mem_addr = fetch_pc;
   assign o_valid    = (o_count != '0);
   assign o_state    = state;

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Parametrised successor to the single-entry RAPID IF stage.
- Runs ahead of decode: issues sequential instruction reads to the instruction memory/cache port and buffers {pc, instr} pairs in a DEPTH-entry queue.
- Decode drains the queue through a valid/ready handshake.
- Supports branch redirect with queue flush, discard of a stale in-flight read, and a halt input.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_halt  in  1  when high, no new memory requests are issued; an in-flight request still completes.
- i_redirect  in  1  branch/jump redirect strobe, single cycle.
- i_redirect_pc  in  XLEN  redirect target.
- o_mem_req  out  1  read request; held high until i_mem_done.
- o_mem_addr  out  XLEN  read address; stable while o_mem_req is high.
- i_mem_done  in  1  one-cycle completion pulse; i_mem_data is valid in the same cycle.
- i_mem_data  in  XLEN  returned instruction word.
- o_valid  out  1  queue head valid.
- i_ready  in  1  decode accepts the head this cycle.
- o_pc  out  XLEN  pc of the head entry.
- o_instr  out  XLEN  instruction of the head entry.
- o_count  out  $clog2(DEPTH+1)  queue occupancy.
- o_state  out  fetch_state_t  FSM state, for verification only.

Behaviour:
- Reset values:
  - state = FQ_IDLE, fetch_pc = RESET_VECTOR, queue empty, o_count = 0.
  - o_valid = 0, o_mem_req = 0, o_pc = 0, o_instr = 0.
- Output decode:
  - o_mem_req = (state != FQ_IDLE); o_mem_addr = fetch_pc.
  - o_valid = (count != 0); o_pc/o_instr come combinationally from the registered head entry.
- FSM, all transitions on the clock edge:
  - FQ_IDLE -> FQ_REQ when !i_halt and count < DEPTH (count after this cycle's pop). The first request after reset appears in the first cycle after reset deasserts.
  - FQ_REQ, on i_mem_done without redirect:
    - push {fetch_pc, i_mem_data}; fetch_pc += 4 (WORD_WIDTH), modulo 2^XLEN.
    - Stay in FQ_REQ if !i_halt and post-update count < DEPTH; otherwise go to FQ_IDLE.
    - Back-to-back requests are allowed: the new address is presented the cycle after done.
  - FQ_DISCARD: waits for i_mem_done, drops the data (no push), then goes to FQ_REQ, or to FQ_IDLE if i_halt.
- Space reservation: at most one request is outstanding, and a request is issued only when count < DEPTH. A push therefore never overflows.
- Pop: occurs when o_valid & i_ready. Push and pop in the same cycle leave count unchanged. Pop while empty is ignored.
- Redirect has highest priority in every state:
  - queue flushed (count = 0 next cycle); any same-cycle pop or push is discarded.
  - fetch_pc <= i_redirect_pc with bits [1:0] cleared.
  - In FQ_REQ without same-cycle i_mem_done: -> FQ_DISCARD.
  - In FQ_REQ with same-cycle i_mem_done: data dropped; -> FQ_REQ at the new pc (FQ_IDLE if i_halt).
  - In FQ_IDLE: -> FQ_REQ next cycle unless i_halt.
  - In FQ_DISCARD: fetch_pc updated, stay in FQ_DISCARD.
- Queue wrap: read/write pointers are $clog2(DEPTH) bits and wrap naturally; occupancy is tracked in a separate counter.
- Reset mid-operation: all state returns to reset values immediately; a pending i_mem_done arriving after reset is ignored, because the FSM is in FQ_IDLE with o_mem_req = 0.
- i_halt while in FQ_REQ: the request completes and is pushed, then the FSM goes to FQ_IDLE. Deasserting i_halt resumes fetch at fetch_pc.

Decomposition:
- rapid_pkg gains:
  - fetch_state_t {FQ_IDLE, FQ_REQ, FQ_DISCARD}.
  - WORD_WIDTH and RESET_VECTOR, reused as the default source.
- Sub-module fetch_queue (params XLEN, DEPTH):
  - synchronous FIFO of {pc, instr} with push, pop, flush, count, head outputs.
  - flush has priority over push and pop.
- prefetch_unit holds the FSM, fetch_pc, and the redirect/discard logic.

Test Plan:
- Reset, i_ready = 0, memory answers in 1 cycle -> requests to 0x0, 0x4, 0x8, 0xC; then o_count = 4, o_mem_req = 0, o_valid = 1, o_pc = 0x0.
- Full queue, then i_ready held high -> head pcs 0x0, 0x4, 0x8, ... in order; refill resumes; no entry lost or duplicated; count never exceeds 4.
- Redirect to 0x103 while a request to 0x8 is outstanding (done arrives 3 cycles later) -> FQ_DISCARD; 0x8 data not pushed; next o_mem_addr = 0x100; first popped o_pc = 0x100.
- Redirect in the same cycle as i_mem_done and i_ready -> no push, no pop, count = 0 next cycle, next request address = the redirect target.
- i_halt asserted mid-request -> that word is pushed, o_mem_req falls the cycle after done; deasserting i_halt resumes at the next sequential pc.
- Asynchronous reset asserted mid-request with count = 2 -> o_valid = 0, o_count = 0, o_mem_req = 0 immediately; first request after release is RESET_VECTOR.
